inst_fetch_queue: RTL and testbench

Parametrised instruction prefetch queue between the instruction bus and the IF/ID pipeline register. It generates sequential fetch addresses, keeps up to MAX_OUTST bus requests in flight, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and presents them to decode through a valid/ready handshake. On a redirect (branch or jalr) it drops buffered entries and in-flight responses and restarts fetch at the new PC.

---
 rtl/inst_fetch_queue_if.sv | 32 +++
 rtl/inst_fetch_queue.sv | 122 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: redirect, instruction-bus request/response and decode-side handshake.
// The master modport is the fetch queue; slave is the surrounding bus/decode environment.
interface inst_fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              req_valid;
    logic [PC_W-1:0]   req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [INST_W-1:0] rsp_inst;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        input  redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_inst, out_ready,
        output req_valid, req_addr, out_valid, out_pc, out_inst, occupancy
    );

    modport slave (
        output redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_inst, out_ready,
        input  req_valid, req_addr, out_valid, out_pc, out_inst, occupancy
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: sequential fetch, credit-limited in-flight requests, {pc,inst} FIFO, redirect flush.
// Optional FETCHQ_BYPASS_EN: a response arriving at an empty queue is presented to decode in the same cycle.
module inst_fetch_queue #(
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter int              PC_W      = 64,
    parameter int              INST_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC  = 64'h8000_0000
) (
    input logic                clk,
    input logic                rst,
    inst_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [TW-1:0] TAG_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [TW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0]     outst_q, outst_d, drop_q, drop_d;
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [PC_W-1:0]   tag_mem_q  [MAX_OUTST];

    logic [AW:0]       occ;
    logic              empty, full, accept, rsp_live, push, pop, byp_take;
    logic [PC_W-1:0]   tag_head;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] t);
        return (t == TW'(MAX_OUTST - 1)) ? '0 : t + TAG_ONE;
    endfunction

    assign occ      = wr_q - rd_q;
    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign tag_head = tag_mem_q[tag_rd_q];

    // Credit rule: queued plus in-flight never exceeds DEPTH, so a response always has a slot.
    assign bus.req_valid = rst && !bus.redirect_valid && (outst_q < CW'(MAX_OUTST))
                           && (32'(occ) + 32'(outst_q) < 32'(DEPTH));
    assign bus.req_addr  = fetch_pc_q;
    assign bus.occupancy = occ;
    assign accept        = bus.req_valid && bus.req_ready;
    assign rsp_live      = bus.rsp_valid && (drop_q == '0) && !bus.redirect_valid;
    assign pop           = !empty && bus.out_ready && !bus.redirect_valid;

`ifdef FETCHQ_BYPASS_EN
    logic byp;
    assign byp           = rst && rsp_live && empty;
    assign byp_take      = byp && bus.out_ready;
    assign bus.out_valid = !empty || byp;
    assign bus.out_pc    = empty ? tag_head : pc_mem_q[rd_q[AW-1:0]];
    assign bus.out_inst  = empty ? bus.rsp_inst : inst_mem_q[rd_q[AW-1:0]];
`else
    assign byp_take      = 1'b0;
    assign bus.out_valid = !empty;
    assign bus.out_pc    = pc_mem_q[rd_q[AW-1:0]];
    assign bus.out_inst  = inst_mem_q[rd_q[AW-1:0]];
`endif

    assign push = rsp_live && !byp_take;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(accept) - CW'(bus.rsp_valid);
        if (accept) begin
            fetch_pc_d = fetch_pc_q + PC_W'(4);
            tag_wr_d   = tag_inc(tag_wr_q);
        end
        if (bus.rsp_valid) tag_rd_d = tag_inc(tag_rd_q);
        // Tags stay in flight across a redirect; only the drop count decides which responses die.
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            rd_d       = wr_q;
            drop_d     = outst_q - CW'(bus.rsp_valid);
        end else begin
            if (push) wr_d = wr_q + PTR_ONE;
            if (pop)  rd_d = rd_q + PTR_ONE;
            if (bus.rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            wr_q       <= '0;
            rd_q       <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_q[AW-1:0]]   <= tag_head;
            inst_mem_q[wr_q[AW-1:0]] <= bus.rsp_inst;
        end
        if (accept) tag_mem_q[tag_wr_q] <= fetch_pc_q;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));
    a_rsp_has_tag:  assert property (@(posedge clk) disable iff (!rst) !(bus.rsp_valid && (outst_q == '0)));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a small in-order bus model; responses carry inst = addr[31:0]^0xCAFE0000.
module tb_inst_fetch_queue;
    localparam logic [63:0] BASE = 64'h8000_0000;
`ifdef FETCHQ_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.DEPTH(4), .PC_W(64), .INST_W(32)) bif ();

    inst_fetch_queue #(
        .DEPTH(4), .MAX_OUTST(2), .PC_W(64), .INST_W(32), .RESET_PC(BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_acc = 0;
    logic        hold = 1'b0;
    logic [63:0] pend[$];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'hCAFE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_rsp();
        bif.rsp_valid = !hold && (pend.size() != 0);
        bif.rsp_inst  = (pend.size() != 0) ? inst_of(pend[0]) : 32'h0;
    endtask

    // One clock: sample handshakes just before the edge, update the bus model after it.
    task automatic tick();
        logic        acc, fire;
        logic [63:0] a;
        #1;
        acc  = bif.req_valid && bif.req_ready;
        a    = bif.req_addr;
        fire = bif.rsp_valid;
        @(posedge clk);
        #1;
        if (fire) void'(pend.pop_front());
        if (acc) begin
            pend.push_back(a);
            n_acc++;
        end
        drive_rsp();
        #1;
    endtask

    task automatic enter_reset();
        rst = 1'b0;
        pend.delete();
        hold  = 1'b0;
        n_acc = 0;
        bif.redirect_valid = 1'b0;
        bif.redirect_pc    = '0;
        bif.req_ready      = 1'b1;
        bif.out_ready      = 1'b1;
        drive_rsp();
        #1;
    endtask

    task automatic leave_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // reset state
        #1;
        enter_reset();
        check("rst_req_valid", 64'(bif.req_valid), 64'd0);
        check("rst_out_valid", 64'(bif.out_valid), 64'd0);
        check("rst_occ", 64'(bif.occupancy), 64'd0);
        leave_reset();
        check("rel_req_valid", 64'(bif.req_valid), 64'd1);
        check("rel_req_addr", bif.req_addr, BASE);

        // streaming, 1-cycle bus, decode always ready
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("stream_addr%0d", i), bif.req_addr, BASE + 64'(4 * i));
            check($sformatf("stream_req_valid%0d", i), 64'(bif.req_valid), 64'd1);
            if (i >= 2 - BYP) begin
                check($sformatf("stream_out_valid%0d", i), 64'(bif.out_valid), 64'd1);
                check($sformatf("stream_out_pc%0d", i), bif.out_pc, BASE + 64'(4 * (i - 2 + BYP)));
                check($sformatf("stream_out_inst%0d", i), 64'(bif.out_inst),
                      64'(inst_of(BASE + 64'(4 * (i - 2 + BYP)))));
                check($sformatf("stream_occ%0d", i), 64'(bif.occupancy), 64'(1 - BYP));
            end else begin
                check("stream_first_latency", 64'(bif.out_valid), 64'd0);
            end
        end

        // fill with decode stalled, then drain
        enter_reset();
        bif.out_ready = 1'b0;
        leave_reset();
        repeat (8) tick();
        check("fill_accepts", 64'(n_acc), 64'd4);
        check("fill_req_valid", 64'(bif.req_valid), 64'd0);
        check("fill_occ", 64'(bif.occupancy), 64'd4);
        check("fill_head_pc", bif.out_pc, BASE);
        bif.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("drain_pc%0d", i), bif.out_pc, BASE + 64'(4 * i));
            if (i == 1) begin
                check("resume_req_valid", 64'(bif.req_valid), 64'd1);
                check("resume_req_addr", bif.req_addr, BASE + 64'h10);
            end
        end

        // redirect with 2 queued and 2 in flight
        enter_reset();
        bif.out_ready = 1'b0;
        leave_reset();
        tick(); tick(); tick();
        hold = 1'b1;
        drive_rsp();
        tick();
        check("redir_pre_occ", 64'(bif.occupancy), 64'd2);
        check("redir_pre_req_valid", 64'(bif.req_valid), 64'd0);
        bif.redirect_valid = 1'b1;
        bif.redirect_pc    = BASE + 64'h1000;
        tick();
        bif.redirect_valid = 1'b0;
        #1;
        check("redir_occ", 64'(bif.occupancy), 64'd0);
        check("redir_out_valid", 64'(bif.out_valid), 64'd0);
        check("redir_req_addr", bif.req_addr, BASE + 64'h1000);
        hold = 1'b0;
        drive_rsp();
        tick();
        check("redir_drop1_occ", 64'(bif.occupancy), 64'd0);
        check("redir_drop1_out_valid", 64'(bif.out_valid), 64'd0);
        check("redir_drop1_req_valid", 64'(bif.req_valid), 64'd1);
        tick();
        check("redir_drop2_occ", 64'(bif.occupancy), 64'd0);
        check("redir_drop2_out_valid", 64'(bif.out_valid), 64'(BYP));
        tick();
        check("redir_first_valid", 64'(bif.out_valid), 64'd1);
        check("redir_first_pc", bif.out_pc, BASE + 64'h1000);
        check("redir_first_inst", 64'(bif.out_inst), 64'(inst_of(BASE + 64'h1000)));

        // redirect coinciding with the only outstanding response
        enter_reset();
        leave_reset();
        tick();
        bif.redirect_valid = 1'b1;
        bif.redirect_pc    = BASE + 64'h2000;
        tick();
        bif.redirect_valid = 1'b0;
        #1;
        check("rsp_redir_occ", 64'(bif.occupancy), 64'd0);
        check("rsp_redir_out_valid", 64'(bif.out_valid), 64'd0);
        check("rsp_redir_req_valid", 64'(bif.req_valid), 64'd1);
        check("rsp_redir_req_addr", bif.req_addr, BASE + 64'h2000);
        tick(); tick();
        check("rsp_redir_first_valid", 64'(bif.out_valid), 64'd1);
        check("rsp_redir_first_pc", bif.out_pc, BASE + 64'h2000);

        // redirect during an active pop
        enter_reset();
        leave_reset();
        tick(); tick();
        check("pop_redir_pre_valid", 64'(bif.out_valid), 64'd1);
        bif.redirect_valid = 1'b1;
        bif.redirect_pc    = BASE + 64'h3000;
        tick();
        bif.redirect_valid = 1'b0;
        #1;
        check("pop_redir_out_valid", 64'(bif.out_valid), 64'd0);
        check("pop_redir_occ", 64'(bif.occupancy), 64'd0);
        check("pop_redir_req_addr", bif.req_addr, BASE + 64'h3000);
        tick(); tick();
        check("pop_redir_first_pc", bif.out_pc, BASE + 64'h3000);

        // asynchronous reset mid-burst with 2 in flight
        enter_reset();
        bif.out_ready = 1'b0;
        leave_reset();
        tick(); tick(); tick();
        hold = 1'b1;
        drive_rsp();
        tick();
        check("burst_pre_occ", 64'(bif.occupancy), 64'd2);
        #2;
        enter_reset();
        check("burst_rst_occ", 64'(bif.occupancy), 64'd0);
        check("burst_rst_out_valid", 64'(bif.out_valid), 64'd0);
        check("burst_rst_req_valid", 64'(bif.req_valid), 64'd0);
        leave_reset();
        check("burst_rel_req_valid", 64'(bif.req_valid), 64'd1);
        check("burst_rel_req_addr", bif.req_addr, BASE);

        // response into an empty queue with decode ready
        enter_reset();
        leave_reset();
        tick();
`ifdef FETCHQ_BYPASS_EN
        check("byp_out_valid", 64'(bif.out_valid), 64'd1);
        check("byp_out_pc", bif.out_pc, BASE);
        check("byp_out_inst", 64'(bif.out_inst), 64'(inst_of(BASE)));
        tick();
        check("byp_occ", 64'(bif.occupancy), 64'd0);
        check("byp_next_pc", bif.out_pc, BASE + 64'h4);
`else
        check("nobyp_out_valid", 64'(bif.out_valid), 64'd0);
        tick();
        check("nobyp_occ", 64'(bif.occupancy), 64'd1);
        check("nobyp_head_pc", bif.out_pc, BASE);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
